mtm_alu_ctrl: RTL and testbench

Sequencer between the frame deserializer, the 32-bit ALU core and the result serializer. Accepts one decoded frame per pulse and classifies it as a good operation or an error. Launches the ALU and waits for completion or timeout, then hands a response word and control byte to the serializer over a valid/ready handshake. Holds one pending frame while busy and counts dropped frames.

---
 rtl/mtm_alu_pkg.sv | 49 ++++
 rtl/mtm_alu_ctrl_slot.sv | 66 ++++++
 rtl/mtm_alu_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mtm_alu_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, error codes, FSM states
// and the frame record that is held in the pending slot.
`timescale 1ns/1ps
package mtm_alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTL_W  = 8;

  // Bit positions inside the incoming control byte
  localparam int CTL_ERR_BIT = 7;
  localparam int CTL_OP_MSB  = 6;
  localparam int CTL_OP_LSB  = 4;

  // Legal ALU opcodes
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Error codes carried in the response control byte
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] ERR_OP   = 8'h93;

  // Positions inside alu_flags = {carry, overflow, zero, negative}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_WAIT_ALU = 3'd2,
    ST_RESP     = 3'd3,
    ST_ERR_RESP = 3'd4
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [CTL_W-1:0]  ctl;
  } frame_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_ctrl_slot.sv
// Depth-1 pending-frame holder with a saturating count of frames that found
// the slot already occupied.
`timescale 1ns/1ps
module mtm_alu_ctrl_slot
  import mtm_alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  frame_t           din_i,
  output frame_t           dout_o,
  output logic             full_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  logic             full_d, full_q;
  frame_t           data_d, data_q;
  logic [CNT_W-1:0] drop_d, drop_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A push is stored when the slot is empty or is being emptied this cycle;
  // otherwise the frame is lost and counted.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    drop_d = drop_q;
    if (pop_i) begin
      full_d = 1'b0;
    end
    if (push_i) begin
      if (!full_q || pop_i) begin
        full_d = 1'b1;
        data_d = din_i;
      end else begin
        drop_d = sat_inc(drop_q);
      end
    end
  end

  // Control state: occupancy flag and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      drop_q <= '0;
    end else begin
      full_q <= full_d;
      drop_q <= drop_d;
    end
  end

  // Frame payload: only meaningful while full_q is set
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign dout_o     = data_q;
  assign full_o     = full_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: rtl/mtm_alu_ctrl.sv
// Sequencer between frame deserializer, ALU core and result serializer.
// Classifies each frame, launches the ALU with a completion timeout and
// presents one response per frame over a valid/ready handshake.
`timescale 1ns/1ps
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_valid,
  input  logic [31:0]       pkt_A,
  input  logic [31:0]       pkt_B,
  input  logic [7:0]        pkt_ctl,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  output logic [31:0]       alu_A,
  output logic [31:0]       alu_B,
  input  logic              alu_done,
  input  logic [31:0]       alu_C,
  input  logic [3:0]        alu_flags,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [31:0]       tx_data,
  output logic [7:0]        tx_ctl,
  output logic              tx_err,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state_d, state_q;
  logic [TMR_W-1:0]  timer_d, timer_q;
  logic              alu_start_d, alu_start_q;
  logic [2:0]        alu_op_d, alu_op_q;
  logic [31:0]       alu_a_d, alu_a_q;
  logic [31:0]       alu_b_d, alu_b_q;
  logic              tx_valid_d, tx_valid_q;
  logic              tx_err_d, tx_err_q;
  logic [31:0]       tx_data_d, tx_data_q;
  logic [7:0]        tx_ctl_d, tx_ctl_q;

  frame_t            pkt_frame, cur_frame, slot_dout;
  logic              slot_push, slot_pop, slot_full;

  assign pkt_frame = '{a: pkt_A, b: pkt_B, ctl: pkt_ctl};

  mtm_alu_ctrl_slot #(
    .CNT_W (CNT_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (slot_push),
    .pop_i      (slot_pop),
    .din_i      (pkt_frame),
    .dout_o     (slot_dout),
    .full_o     (slot_full),
    .drop_cnt_o (drop_cnt)
  );

  // Next-state and registered-output computation; the pending frame is older
  // than a frame arriving now, so it is served first.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    alu_start_d = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    tx_valid_d  = tx_valid_q;
    tx_err_d    = tx_err_q;
    tx_data_d   = tx_data_q;
    tx_ctl_d    = tx_ctl_q;
    slot_pop    = 1'b0;
    slot_push   = pkt_valid;
    cur_frame   = slot_full ? slot_dout : pkt_frame;

    case (state_q)
      ST_IDLE: begin
        if (pkt_valid || slot_full) begin
          slot_pop  = slot_full;
          slot_push = pkt_valid && slot_full;
          if (cur_frame.ctl[CTL_ERR_BIT]) begin
            state_d    = ST_ERR_RESP;
            tx_valid_d = 1'b1;
            tx_err_d   = 1'b1;
            tx_data_d  = '0;
            tx_ctl_d   = cur_frame.ctl;
          end else if (!op_legal(cur_frame.ctl[CTL_OP_MSB:CTL_OP_LSB])) begin
            state_d    = ST_ERR_RESP;
            tx_valid_d = 1'b1;
            tx_err_d   = 1'b1;
            tx_data_d  = '0;
            tx_ctl_d   = ERR_OP;
          end else begin
            state_d  = ST_LAUNCH;
            alu_op_d = cur_frame.ctl[CTL_OP_MSB:CTL_OP_LSB];
            alu_a_d  = cur_frame.a;
            alu_b_d  = cur_frame.b;
          end
        end
      end

      ST_LAUNCH: begin
        alu_start_d = 1'b1;
        timer_d     = '0;
        state_d     = ST_WAIT_ALU;
      end

      ST_WAIT_ALU: begin
        if (alu_done) begin
          state_d    = ST_RESP;
          tx_valid_d = 1'b1;
          tx_err_d   = 1'b0;
          tx_data_d  = alu_C;
          tx_ctl_d   = {1'b0, alu_flags[FLAG_C], alu_flags[FLAG_V],
                        alu_flags[FLAG_Z], alu_flags[FLAG_N], 3'b000};
        end else if (timer_q == TMR_LAST) begin
          state_d    = ST_ERR_RESP;
          tx_valid_d = 1'b1;
          tx_err_d   = 1'b1;
          tx_data_d  = '0;
          tx_ctl_d   = ERR_OP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RESP, ST_ERR_RESP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, timer and every output register clear together on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      tx_valid_q  <= 1'b0;
      tx_err_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_ctl_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      alu_start_q <= alu_start_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      tx_valid_q  <= tx_valid_d;
      tx_err_q    <= tx_err_d;
      tx_data_q   <= tx_data_d;
      tx_ctl_q    <= tx_ctl_d;
    end
  end

  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_A     = alu_a_q;
  assign alu_B     = alu_b_q;
  assign tx_valid  = tx_valid_q;
  assign tx_err    = tx_err_q;
  assign tx_data   = tx_data_q;
  assign tx_ctl    = tx_ctl_q;
  assign busy      = (state_q != ST_IDLE) || slot_full;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Directed bench for mtm_alu_ctrl: good op, pass-through and op errors,
// timeout, backpressure, pending slot overflow/saturation, async reset.
`timescale 1ns/1ps
module tb_mtm_alu_ctrl;
  import mtm_alu_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pkt_valid;
  logic [31:0]       pkt_A, pkt_B;
  logic [7:0]        pkt_ctl;
  logic              alu_start;
  logic [2:0]        alu_op;
  logic [31:0]       alu_A, alu_B;
  logic              alu_done;
  logic [31:0]       alu_C;
  logic [3:0]        alu_flags;
  logic              tx_valid, tx_ready, tx_err, busy;
  logic [31:0]       tx_data;
  logic [7:0]        tx_ctl;
  logic [CNT_W-1:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int acc_cnt = 0;

  mtm_alu_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pkt_valid (pkt_valid),
    .pkt_A     (pkt_A),
    .pkt_B     (pkt_B),
    .pkt_ctl   (pkt_ctl),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .alu_A     (alu_A),
    .alu_B     (alu_B),
    .alu_done  (alu_done),
    .alu_C     (alu_C),
    .alu_flags (alu_flags),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_ctl    (tx_ctl),
    .tx_err    (tx_err),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (alu_start) start_cnt++;
    if (tx_valid && tx_ready) acc_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    pkt_valid = 1'b1;
    pkt_A     = a;
    pkt_B     = b;
    pkt_ctl   = c;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    drive_pkt(a, b, c);
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic accept();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pkt_valid = 1'b0; pkt_A = '0; pkt_B = '0; pkt_ctl = '0;
    alu_done = 1'b0; alu_C = '0; alu_flags = '0; tx_ready = 1'b0;
    tick(); tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_tx_ctl", tx_ctl, 0);
    rst_n = 1'b1;
    tick();

    // Good ADD
    send(32'h0000_0001, 32'hFFFF_FFFF, 8'h40);
    chk("add_launch_start", alu_start, 0);
    chk("add_op", alu_op, 3'b100);
    chk("add_A", alu_A, 32'h1);
    chk("add_B", alu_B, 32'hFFFF_FFFF);
    chk("add_busy", busy, 1);
    tick();
    chk("add_start", alu_start, 1);
    tick();
    chk("add_start_once", alu_start, 0);
    chk("add_no_tx_yet", tx_valid, 0);
    alu_done = 1'b1; alu_C = 32'h0; alu_flags = 4'b1010;
    tick();
    alu_done = 1'b0;
    chk("add_tx_valid", tx_valid, 1);
    chk("add_tx_data", tx_data, 32'h0);
    chk("add_tx_ctl", tx_ctl, 8'h50);
    chk("add_tx_err", tx_err, 0);
    accept();
    chk("add_done_valid", tx_valid, 0);
    chk("add_idle", busy, 0);
    chk("add_start_cnt", start_cnt, 1);

    // Deserializer pass-through errors
    send(32'h1234, 32'h5678, ERR_CRC);
    chk("crc_valid", tx_valid, 1);
    chk("crc_err", tx_err, 1);
    chk("crc_ctl", tx_ctl, 8'hA5);
    chk("crc_data", tx_data, 0);
    accept();
    send(32'h1234, 32'h5678, ERR_DATA);
    chk("data_valid", tx_valid, 1);
    chk("data_ctl", tx_ctl, 8'hC9);
    chk("data_err", tx_err, 1);
    accept();
    chk("err_no_start", start_cnt, 1);

    // Illegal op with 10 cycles of backpressure
    send(32'h1, 32'h2, 8'h30);
    chk("ill_valid", tx_valid, 1);
    chk("ill_ctl", tx_ctl, 8'h93);
    chk("ill_err", tx_err, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", tx_valid, 1);
      chk("bp_ctl", tx_ctl, 8'h93);
      chk("bp_data", tx_data, 0);
    end
    accept();
    chk("bp_released", tx_valid, 0);
    chk("bp_idle", busy, 0);
    chk("ill_no_start", start_cnt, 1);
    chk("acc_so_far", acc_cnt, 4);

    // Timeout: no alu_done at all
    send(32'h7, 32'h3, 8'h00);
    tick();
    chk("to_start", alu_start, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("to_not_yet", tx_valid, 0);
    tick();
    chk("to_valid", tx_valid, 1);
    chk("to_ctl", tx_ctl, 8'h93);
    chk("to_err", tx_err, 1);
    accept();

    // alu_done on the last allowed cycle beats the timeout
    send(32'h7, 32'h3, 8'h40);
    tick();
    chk("tie_start", alu_start, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    alu_done = 1'b1; alu_C = 32'hDEAD_BEEF; alu_flags = 4'b0001;
    tick();
    alu_done = 1'b0;
    chk("tie_valid", tx_valid, 1);
    chk("tie_err", tx_err, 0);
    chk("tie_ctl", tx_ctl, 8'h08);
    chk("tie_data", tx_data, 32'hDEAD_BEEF);
    accept();

    // Stray alu_done in IDLE is ignored
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    chk("stray_done", tx_valid, 0);

    // Overflow of the pending slot
    send(32'h5, 32'h3, 8'h50);
    tick();
    drive_pkt(32'hF0, 32'h0F, 8'h10);
    tick();
    drive_pkt(32'h1, 32'h1, 8'h40);
    tick();
    drive_pkt(32'h2, 32'h2, 8'h40);
    tick();
    pkt_valid = 1'b0;
    chk("ovf_drop2", drop_cnt, 2);
    chk("ovf_busy", busy, 1);
    alu_done = 1'b1; alu_C = 32'h2; alu_flags = 4'b0000;
    tick();
    alu_done = 1'b0;
    chk("ovf_sub_data", tx_data, 32'h2);
    chk("ovf_sub_ctl", tx_ctl, 8'h00);
    accept();
    chk("ovf_idle_valid", tx_valid, 0);
    chk("ovf_idle_busy", busy, 1);
    // Hand-off: arrival in IDLE with the slot full is kept, not dropped
    send(32'h0, 32'h0, ERR_CRC);
    chk("hand_drop", drop_cnt, 2);
    chk("hand_op", alu_op, 3'b001);
    chk("hand_A", alu_A, 32'hF0);
    chk("hand_B", alu_B, 32'h0F);
    tick();
    chk("hand_start", alu_start, 1);
    send(32'h3, 32'h3, 8'h40);
    chk("sat_3", drop_cnt, 3);
    send(32'h4, 32'h4, 8'h40);
    chk("sat_hold", drop_cnt, 3);

    // Async reset mid-WAIT_ALU with a pending frame
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_op", alu_op, 0);
    chk("ar_A", alu_A, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_valid", tx_valid, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_quiet", tx_valid, 0);
    end
    chk("post_rst_start_cnt", start_cnt, 5);
    send(32'h0, 32'h0, ERR_DATA);
    chk("post_rst_new_valid", tx_valid, 1);
    chk("post_rst_new_ctl", tx_ctl, 8'hC9);
    accept();
    chk("post_rst_idle", busy, 0);
    chk("acc_total", acc_cnt, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
